// File: rtl/tcm_access_arbiter.sv
// Two-requester arbiter for a single-port TCM: round-robin between the stream
// write path (r0, bursts held under a lock) and the register path (r1).
module tcm_access_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  tcm_aclk,
    input  logic                  tcm_areset,
    input  logic                  r0_valid,
    output logic                  r0_ready,
    input  logic [ADDR_WIDTH-1:0] r0_addr,
    input  logic [DATA_WIDTH-1:0] r0_wdata,
    input  logic                  r0_last,
    input  logic                  r1_valid,
    output logic                  r1_ready,
    input  logic                  r1_we,
    input  logic [ADDR_WIDTH-1:0] r1_addr,
    input  logic [DATA_WIDTH-1:0] r1_wdata,
    output logic                  r1_rsp_valid,
    output logic [DATA_WIDTH-1:0] r1_rsp_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  stat_clr,
    output logic [CNT_WIDTH-1:0]  r0_stall_cnt,
    output logic [CNT_WIDTH-1:0]  r1_stall_cnt
);

    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] BEAT_REL = BW'(MAX_BURST - 1);

    typedef enum logic {IDLE, LOCK0} state_t;

    state_t                 state_q, state_d;
    logic [BW-1:0]          beat_cnt_q, beat_cnt_d;
    logic                   last_grant_q, last_grant_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [CNT_WIDTH-1:0]   r0_cnt_q, r0_cnt_d;
    logic [CNT_WIDTH-1:0]   r1_cnt_q, r1_cnt_d;
    logic                   gnt0, gnt1;
    logic                   stall0, stall1;

    // Grants are forced low during reset so every output reads 0 then.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!tcm_areset) begin
            unique case (state_q)
                LOCK0: gnt0 = r0_valid;
                IDLE: begin
                    gnt0 = r0_valid && (!r1_valid || last_grant_q);
                    gnt1 = r1_valid && (!r0_valid || !last_grant_q);
                end
            endcase
        end
    end

    assign r0_ready     = gnt0;
    assign r1_ready     = gnt1;
    assign mem_en       = gnt0 | gnt1;
    assign mem_we       = gnt0 | (gnt1 & r1_we);
    assign mem_addr     = gnt0 ? r0_addr  : (gnt1 ? r1_addr  : '0);
    assign mem_wdata    = gnt0 ? r0_wdata : (gnt1 ? r1_wdata : '0);
    assign r1_rsp_valid = rsp_valid_q;
    assign r1_rsp_rdata = rsp_valid_q ? mem_rdata : '0;
    assign r0_stall_cnt = r0_cnt_q;
    assign r1_stall_cnt = r1_cnt_q;

    assign stall0 = r0_valid & ~gnt0;
    assign stall1 = r1_valid & ~gnt1;

    always_comb begin
        state_d      = state_q;
        beat_cnt_d   = beat_cnt_q;
        last_grant_d = last_grant_q;
        rsp_valid_d  = gnt1 & ~r1_we;
        if (gnt0) begin
            last_grant_d = 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (!r0_last && MAX_BURST > 1) begin
                        state_d    = LOCK0;
                        beat_cnt_d = BW'(1);
                    end
                end
                LOCK0: begin
                    if (r0_last || beat_cnt_q == BEAT_REL) begin
                        state_d    = IDLE;
                        beat_cnt_d = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + BW'(1);
                    end
                end
            endcase
        end
        if (gnt1) begin
            last_grant_d = 1'b1;
        end
    end

    // Clear wins over increment; counts stick at all-ones.
    always_comb begin
        r0_cnt_d = r0_cnt_q;
        r1_cnt_d = r1_cnt_q;
        if (stat_clr) begin
            r0_cnt_d = '0;
            r1_cnt_d = '0;
        end else begin
            if (stall0 && r0_cnt_q != '1) r0_cnt_d = r0_cnt_q + 1'b1;
            if (stall1 && r1_cnt_q != '1) r1_cnt_d = r1_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge tcm_aclk) begin
        if (tcm_areset) begin
            state_q      <= IDLE;
            beat_cnt_q   <= '0;
            last_grant_q <= 1'b1;
            rsp_valid_q  <= 1'b0;
            r0_cnt_q     <= '0;
            r1_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            last_grant_q <= last_grant_d;
            rsp_valid_q  <= rsp_valid_d;
            r0_cnt_q     <= r0_cnt_d;
            r1_cnt_q     <= r1_cnt_d;
        end
    end

endmodule
